// File: rtl/seq_divider_32bit.sv
// Restoring shift-subtract divider, one quotient bit per clock, 32-clock latency.
// Define DIV_SIGNED_EN to add two's-complement operand/result sign handling.
module seq_divider_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             divisor_zero;
  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] mag_dvd;
  logic [WIDTH-1:0] mag_dvs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign divisor_zero = (divisor == '0);
  assign accept       = start && (state_q != StRun);
  assign last_iter    = (state_q == StRun) && (count_q == LastCnt);

  // ---------------------------------------------------------------------------
  // Operand magnitudes and result sign correction
  // ---------------------------------------------------------------------------
`ifdef DIV_SIGNED_EN
  logic dvd_neg;
  logic dvs_neg;
  logic neg_quo_q;
  logic neg_rem_q;

  assign dvd_neg = signed_op && dividend[WIDTH-1];
  assign dvs_neg = signed_op && divisor[WIDTH-1];
  assign mag_dvd = dvd_neg ? (WIDTH'(0) - dividend) : dividend;
  assign mag_dvs = dvs_neg ? (WIDTH'(0) - divisor) : divisor;
  // INT_MIN / -1 wraps back to INT_MIN through the negation, with no flag.
  assign quo_fix = neg_quo_q ? (WIDTH'(0) - quo_step) : quo_step;
  assign rem_fix = neg_rem_q ? (WIDTH'(0) - rem_step) : rem_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept && !divisor_zero) begin
      neg_quo_q <= dvd_neg ^ dvs_neg;
      neg_rem_q <= dvd_neg;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign mag_dvd          = dividend;
  assign mag_dvs          = divisor;
  assign quo_fix          = quo_step;
  assign rem_fix          = rem_step;
`endif

  // ---------------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------------
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  // Two guard bits: the shifted remainder can itself need WIDTH+1 bits.
  assign trial    = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign fits     = ~trial[WIDTH+1];
  assign rem_step = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_step = {dvd_q[WIDTH-2:0], fits};

  // ---------------------------------------------------------------------------
  // FSM: state register, next-state logic, outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = divisor_zero ? StDone : StRun;
        end
      end
      StRun: begin
        if (count_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (start) begin
          state_d = divisor_zero ? StDone : StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      if (divisor_zero) begin
        quotient_q  <= '1;
        remainder_q <= dividend;
        dbz_q       <= 1'b1;
      end else begin
        dvd_q   <= mag_dvd;
        dvs_q   <= mag_dvs;
        rem_q   <= '0;
        count_q <= '0;
        dbz_q   <= 1'b0;
      end
    end else if (state_q == StRun) begin
      rem_q   <= rem_step;
      dvd_q   <= quo_step;
      count_q <= count_q + 1'b1;
      if (last_iter) begin
        quotient_q  <= quo_fix;
        remainder_q <= rem_fix;
      end
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Directed bench for seq_divider_32bit: vector table plus mid-run start and reset sequences.
module tb_seq_divider_32bit;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider_32bit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
  endtask

  // Counts negedges after the start-driving negedge until done; n=33 for a full run.
  task automatic wait_done(input int ign_at, output int n, output int busy_cnt,
                           output logic overlap);
    n        = 41;
    busy_cnt = 0;
    overlap  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == ign_at) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  vec_t vecs[14];
  int   n;
  int   bc;
  logic ov;
  logic saw_done;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,        1'b0};
    vecs[1]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,        1'b0};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,        1'b0};
    vecs[3]  = '{1'b0, 32'd55,         32'd0,          32'hFFFFFFFF,   32'd55,       1'b1};
    vecs[4]  = '{1'b0, 32'd20,         32'd6,          32'd3,          32'd2,        1'b0};
    vecs[5]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,        1'b0};
    vecs[6]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,        1'b0};
    vecs[7]  = '{1'b0, 32'h12345678,   32'h100,        32'h00123456,   32'h78,       1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,        1'b0};
    vecs[9]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB, 1'b1};
`ifdef DIV_SIGNED_EN
    vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF, 1'b0};
    vecs[11] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,        1'b0};
    vecs[12] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,        1'b0};
    vecs[13] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF, 1'b0};
`else
    vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,        1'b0};
    vecs[11] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000, 1'b0};
    vecs[12] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'd0,          32'd7,        1'b0};
    vecs[13] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd0,          32'hFFFFFFF9, 1'b0};
`endif

    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("reset_quotient",  quotient,            32'd0);
    check("reset_remainder", remainder,           32'd0);
    check("reset_busy",      32'(busy),           32'd0);
    check("reset_done",      32'(done),           32'd0);
    check("reset_dbz",       32'(div_by_zero),    32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(0, n, bc, ov);
      check($sformatf("v%0d_latency", i),   32'(n),           vecs[i].dbz ? 32'd1 : 32'd33);
      check($sformatf("v%0d_busy_cnt", i),  32'(bc),          vecs[i].dbz ? 32'd0 : 32'd32);
      check($sformatf("v%0d_overlap", i),   32'(ov),          32'd0);
      check($sformatf("v%0d_quotient", i),  quotient,         vecs[i].q);
      check($sformatf("v%0d_remainder", i), remainder,        vecs[i].r);
      check($sformatf("v%0d_dbz", i),       32'(div_by_zero), 32'(vecs[i].dbz));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(done),       32'd0);
      check($sformatf("v%0d_hold_q", i),     quotient,        vecs[i].q);
    end

    // start mid-run is ignored; start during DONE is accepted back-to-back
    issue(1'b0, 32'd100, 32'd7);
    wait_done(10, n, bc, ov);
    check("ign_latency",   32'(n),    32'd33);
    check("ign_quotient",  quotient,  32'd14);
    check("ign_remainder", remainder, 32'd2);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    wait_done(0, n, bc, ov);
    check("b2b_latency",   32'(n),    32'd33);
    check("b2b_busy_cnt",  32'(bc),   32'd32);
    check("b2b_quotient",  quotient,  32'd3);
    check("b2b_remainder", remainder, 32'd0);

    // asynchronous reset mid-run
    issue(1'b0, 32'd100, 32'd7);
    repeat (15) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_busy",      32'(busy),        32'd0);
    check("rst_done",      32'(done),        32'd0);
    check("rst_quotient",  quotient,         32'd0);
    check("rst_remainder", remainder,        32'd0);
    check("rst_dbz",       32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("rst_no_done", 32'(saw_done), 32'd0);
    issue(1'b0, 32'd20, 32'd6);
    wait_done(0, n, bc, ov);
    check("post_rst_latency",   32'(n),    32'd33);
    check("post_rst_quotient",  quotient,  32'd3);
    check("post_rst_remainder", remainder, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
